// File: rtl/pipelined_cla_adder.sv
// Pipelined N-bit carry-look-ahead adder/subtractor. Each stage adds one
// B-bit block and passes the block carry forward, with valid/ready flow control.
module pipelined_cla_adder #(
    parameter int N = 16,
    parameter int B = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int S = N / B;

    // Returns {carry out, carry into block msb, block sum}, carries fully expanded.
    function automatic logic [B+1:0] cla_block(
        input logic [B-1:0] x,
        input logic [B-1:0] y,
        input logic         ci
    );
        logic [B-1:0] g;
        logic [B-1:0] p;
        logic [B:0]   c;
        logic         term;
        g = x & y;
        p = x ^ y;
        c = '0;
        c[0] = ci;
        for (int i = 0; i < B; i++) begin
            term = ci;
            for (int k = 0; k <= i; k++) term = term & p[k];
            c[i+1] = term;
            for (int k = 0; k <= i; k++) begin
                term = g[k];
                for (int m = k + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[B], c[B-1], p ^ c[B-1:0]};
    endfunction

    logic [S-1:0] valid;
    logic [S-1:0] adv;
    logic [S-1:0] c_r;
    logic         ovf_r;
    logic [N-1:0] a_r   [S];
    logic [N-1:0] b_r   [S];
    logic [N-1:0] sum_r [S];

    logic [S-1:0] stage_in_valid;
    logic [S-1:0] stage_c;
    logic [N-1:0] stage_a   [S];
    logic [N-1:0] stage_b   [S];
    logic [N-1:0] stage_sum [S];
    logic [N-1:0] next_sum  [S];
    logic [B+1:0] res       [S];

    // A stage may load when it is empty or its contents move on downstream.
    always_comb begin
        logic go;
        go = out_ready;
        adv = '0;
        for (int j = S - 1; j >= 0; j--) begin
            go = !valid[j] || go;
            adv[j] = go;
        end
    end

    assign in_ready = adv[0];

    // Stage 0 takes the operands directly; subtraction folds into a + ~b + 1.
    always_comb begin
        stage_in_valid[0] = in_valid;
        stage_a[0]        = a;
        stage_b[0]        = sub ? ~b : b;
        stage_c[0]        = sub | cin;
        stage_sum[0]      = '0;
        for (int j = 1; j < S; j++) begin
            stage_in_valid[j] = valid[j-1];
            stage_a[j]        = a_r[j-1];
            stage_b[j]        = b_r[j-1];
            stage_c[j]        = c_r[j-1];
            stage_sum[j]      = sum_r[j-1];
        end
        for (int j = 0; j < S; j++) begin
            res[j] = cla_block(stage_a[j][j*B +: B], stage_b[j][j*B +: B], stage_c[j]);
            next_sum[j] = stage_sum[j];
            next_sum[j][j*B +: B] = res[j][B-1:0];
        end
    end

    // Pipeline registers; a stalled stage holds everything, including outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            c_r   <= '0;
            ovf_r <= 1'b0;
            for (int j = 0; j < S; j++) begin
                a_r[j]   <= '0;
                b_r[j]   <= '0;
                sum_r[j] <= '0;
            end
        end else begin
            for (int j = 0; j < S; j++) begin
                if (adv[j]) begin
                    valid[j] <= stage_in_valid[j];
                    a_r[j]   <= stage_a[j];
                    b_r[j]   <= stage_b[j];
                    sum_r[j] <= next_sum[j];
                    c_r[j]   <= res[j][B+1];
                end
            end
            if (adv[S-1]) begin
                ovf_r <= res[S-1][B+1] ^ res[S-1][B];
            end
        end
    end

    assign out_valid = valid[S-1];
    assign s         = sum_r[S-1];
    assign cout      = c_r[S-1];
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomised and directed bench for pipelined_cla_adder (N=16, B=4), with an
// arithmetic reference model and an in-order scoreboard of accepted beats.
module tb_pipelined_cla_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    pipelined_cla_adder #(.N(16), .B(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          acc_count = 0;
    int          res_count = 0;
    logic [17:0] exp_q[$];
    logic        obs_accept;
    logic        obs_valid;
    logic        obs_in_ready;
    logic [17:0] last_result;
    logic        stall_prev = 1'b0;
    logic [17:0] held;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference: plain integer arithmetic, result packed as {ovf, cout, s}.
    function automatic logic [17:0] refModel(input logic [15:0] x, input logic [15:0] y,
                                             input logic ci, input logic sb);
        int ux, uy, sx, sy, us, ss;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sb) begin
            us = ux - uy;
            ss = sx - sy;
            co = (ux >= uy);
        end else begin
            us = ux + uy + int'(ci);
            ss = sx + sy + int'(ci);
            co = (us > 65535);
        end
        ov = (ss > 32767) || (ss < -32768);
        return {ov, co, us[15:0]};
    endfunction

    // One cycle: drive at negedge, sample 1 time unit later, then wait for next negedge.
    task automatic applyStimulus(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                                 input logic icin, input logic isub, input logic ordy);
        logic [17:0] cur;
        logic [17:0] e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = icin;
        sub       = isub;
        out_ready = ordy;
        #1;
        cur          = {ovf, cout, s};
        obs_accept   = in_valid && in_ready;
        obs_valid    = out_valid;
        obs_in_ready = in_ready;
        if (stall_prev) checkOutput("stall_hold", 32'({out_valid, cur}), 32'({1'b1, held}));
        stall_prev = out_valid && !out_ready;
        held = cur;
        if (obs_accept) begin
            exp_q.push_back(refModel(ia, ib, icin, isub));
            acc_count++;
        end
        if (out_valid && out_ready) begin
            res_count++;
            last_result = cur;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 32'(cur), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                checkOutput("result", 32'(cur), 32'(e));
            end
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        stall_prev = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_outputs", 32'({ovf, cout, s}), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic runSingle(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic ci, input logic sb, input logic [17:0] want);
        int n;
        applyStimulus(1'b1, x, y, ci, sb, 1'b1);
        checkOutput("single_accept", 32'(obs_accept), 32'd1);
        for (n = 1; n <= 20; n++) begin
            applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
            if (obs_valid) break;
        end
        checkOutput("latency", 32'(n), 32'd4);
        checkOutput(tag, 32'(last_result), 32'(want));
    endtask

    logic [15:0] bp_a [6];
    logic [15:0] bp_b [6];
    logic        bp_c [6];
    logic        bp_s [6];
    int          idx;
    int          acc0;
    int          res0;
    int          sent;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        doReset();

        runSingle("add_10_20",   16'd10,    16'd20,    1'b0, 1'b0, {1'b0, 1'b0, 16'd30});
        runSingle("add_50_70",   16'd50,    16'd70,    1'b0, 1'b0, {1'b0, 1'b0, 16'd120});
        runSingle("add_143_143", 16'd143,   16'd143,   1'b1, 1'b0, {1'b0, 1'b0, 16'd287});
        runSingle("ripple_all",  16'hFFFF,  16'h0000,  1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
        runSingle("sub_50_70",   16'd50,    16'd70,    1'b1, 1'b1, {1'b0, 1'b0, 16'hFFEC});
        runSingle("sub_70_50",   16'd70,    16'd50,    1'b0, 1'b1, {1'b0, 1'b1, 16'd20});
        runSingle("ovf_add",     16'h7FFF,  16'h0001,  1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        runSingle("ovf_sub",     16'h8000,  16'h0001,  1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});

        // Backpressure: fill with output stalled, then release.
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 16'($urandom);
            bp_b[i] = 16'($urandom);
            bp_c[i] = 1'($urandom);
            bp_s[i] = 1'($urandom);
        end
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 6) applyStimulus(1'b1, bp_a[idx], bp_b[idx], bp_c[idx], bp_s[idx], 1'b0);
            else applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
            if (obs_accept) idx++;
        end
        checkOutput("bp_accepted", 32'(idx), 32'd4);
        checkOutput("bp_full_ready", 32'(obs_in_ready), 32'd0);
        if (idx < 6) applyStimulus(1'b1, bp_a[idx], bp_b[idx], bp_c[idx], bp_s[idx], 1'b1);
        else applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_ready_rise", 32'(obs_in_ready), 32'd1);
        if (obs_accept) idx++;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            applyStimulus(1'b1, bp_a[idx], bp_b[idx], bp_c[idx], bp_s[idx], 1'b1);
            if (obs_accept) idx++;
        end
        checkOutput("bp_all_sent", 32'(idx), 32'd6);
        drain();

        // Random streaming with bubbles on both sides; a beat is held until taken.
        acc0 = acc_count;
        res0 = res_count;
        sent = 0;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            applyStimulus($urandom_range(0, 9) < 7, ra, rb, rc, rs, $urandom_range(0, 9) < 7);
            if (obs_accept) begin
                sent++;
                ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            end
        end
        checkOutput("stream_sent", 32'(sent), 32'd1000);
        drain();
        checkOutput("stream_inout", 32'(res_count - res0), 32'(acc_count - acc0));

        // Reset with three beats in flight; none of them may ever appear.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("flight_count", 32'(exp_q.size()), 32'd3);
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        runSingle("post_reset", 16'd1, 16'd2, 1'b0, 1'b0, {1'b0, 1'b0, 16'd3});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
